// File: rtl/clock_pkg.sv
// Shared state encoding and time-field limits for the alarm controller.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_ARMED    = 3'd4,
        ST_RINGING  = 3'd5,
        ST_SNOOZE   = 3'd6,
        ST_ILLEGAL  = 3'd7
    } state_e;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    function automatic logic is_set_state(input state_e s);
        return (s == ST_SET_HOUR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
    endfunction

endpackage

// File: rtl/alarm_field_cnt.sv
// Modulo-(MAX+1) increment-only counter holding one alarm time field.
module alarm_field_cnt #(
    parameter int MAX = 59,
    localparam int W  = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= (cnt_q == W'(MAX)) ? '0 : cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: field setting, match-edge trigger, timed ring.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
//
//   state    | meaning
//   IDLE     | alarm disarmed, waiting for btn_mode
//   SET_HOUR | btn_inc steps alarm hour
//   SET_MIN  | btn_inc steps alarm minute
//   SET_SEC  | btn_inc steps alarm second
//   ARMED    | waiting for rising edge of time match
//   RINGING  | buzzer on, ring counter counts down on tick_1hz
//   SNOOZE   | buzzer paused, snooze counter counts down (snooze build only)
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_stop,
    input  logic       alarm_en,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic [5:0] alarm_sec,
    output logic [2:0] state,
    output logic       setting,
    output logic       ring
);

    localparam int RING_W = $clog2(RING_SECS + 1);

    if (RING_SECS < 1 || RING_SECS > 255) begin : g_bad_ring
        $error("RING_SECS must be within 1..255");
    end
    if (SNOOZE_SECS < 1 || SNOOZE_SECS > 1023) begin : g_bad_snooze
        $error("SNOOZE_SECS must be within 1..1023");
    end

    state_e              state_q, state_d;
    logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic                ring_q, setting_q, match_q;
    logic                match, trigger, inc_ok;

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = $clog2(SNOOZE_SECS + 1);
    logic [SNZ_W-1:0]    snz_cnt_q, snz_cnt_d;
`endif

    // btn_stop and btn_mode both outrank btn_inc in the same cycle
    assign inc_ok = btn_inc && !btn_stop && !btn_mode;

    alarm_field_cnt #(.MAX(HOUR_MAX)) u_hour (
        .clk_i(clock), .rst_n_i(reset_n),
        .inc_i(inc_ok && state_q == ST_SET_HOUR), .cnt_o(alarm_hour)
    );
    alarm_field_cnt #(.MAX(MIN_MAX)) u_min (
        .clk_i(clock), .rst_n_i(reset_n),
        .inc_i(inc_ok && state_q == ST_SET_MIN), .cnt_o(alarm_min)
    );
    alarm_field_cnt #(.MAX(SEC_MAX)) u_sec (
        .clk_i(clock), .rst_n_i(reset_n),
        .inc_i(inc_ok && state_q == ST_SET_SEC), .cnt_o(alarm_sec)
    );

    assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == alarm_sec);
    assign trigger = match && !match_q;

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        case (state_q)
            ST_IDLE:     if (!btn_stop && btn_mode) state_d = ST_SET_HOUR;
            ST_SET_HOUR: if (!btn_stop && btn_mode) state_d = ST_SET_MIN;
            ST_SET_MIN:  if (!btn_stop && btn_mode) state_d = ST_SET_SEC;
            ST_SET_SEC:  if (!btn_stop && btn_mode) state_d = alarm_en ? ST_ARMED : ST_IDLE;
            ST_ARMED: begin
                if (!alarm_en) begin
                    state_d = ST_IDLE;
                end else if (!btn_stop && btn_mode) begin
                    state_d = ST_SET_HOUR;
                end else if (!btn_stop && trigger) begin
                    state_d    = ST_RINGING;
                    ring_cnt_d = RING_W'(RING_SECS);
                end
            end
            ST_RINGING: begin
                if (!alarm_en) begin
                    state_d    = ST_IDLE;
                    ring_cnt_d = '0;
                end else if (btn_stop) begin
                    state_d    = ST_ARMED;
                    ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
                end else if (inc_ok) begin
                    state_d    = ST_SNOOZE;
                    ring_cnt_d = '0;
                    snz_cnt_d  = SNZ_W'(SNOOZE_SECS);
`endif
                end else if (tick_1hz) begin
                    if (ring_cnt_q <= RING_W'(1)) begin
                        state_d    = ST_ARMED;
                        ring_cnt_d = '0;
                    end else begin
                        ring_cnt_d = ring_cnt_q - RING_W'(1);
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (!alarm_en) begin
                    state_d   = ST_IDLE;
                    snz_cnt_d = '0;
                end else if (btn_stop) begin
                    state_d   = ST_ARMED;
                    snz_cnt_d = '0;
                end else if (tick_1hz) begin
                    if (snz_cnt_q <= SNZ_W'(1)) begin
                        state_d    = ST_RINGING;
                        snz_cnt_d  = '0;
                        ring_cnt_d = RING_W'(RING_SECS);
                    end else begin
                        snz_cnt_d = snz_cnt_q - SNZ_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
                snz_cnt_d  = '0;
`endif
            end
        endcase
    end

    // match_q resets high so a match present at reset release cannot trigger
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            ring_q     <= 1'b0;
            setting_q  <= 1'b0;
            match_q    <= 1'b1;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            ring_q     <= (state_d == ST_RINGING);
            setting_q  <= is_set_state(state_d);
            match_q    <= match;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
`endif
        end
    end

    assign state   = state_q;
    assign ring    = ring_q;
    assign setting = setting_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (RING_SECS=3, SNOOZE_SECS=2).
module tb_alarm_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick_1hz, btn_mode, btn_inc, btn_stop, alarm_en;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min, alarm_sec;
    logic [2:0] state;
    logic       setting, ring;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alarm_ctrl #(.RING_SECS(3), .SNOOZE_SECS(2)) dut (
        .clock(clock), .reset_n(reset_n), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_stop(btn_stop),
        .alarm_en(alarm_en), .cur_hour(cur_hour), .cur_min(cur_min),
        .cur_sec(cur_sec), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_sec(alarm_sec), .state(state), .setting(setting), .ring(ring)
    );

    typedef struct {
        logic       mode, inc, stop, en;
        logic [2:0] e_state;
        logic       e_set, e_ring;
        logic [5:0] e_sec;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic m, i, s, e, input logic [2:0] st,
                                input logic se, r, input logic [5:0] sc);
        vec_t v;
        v.mode = m; v.inc = i; v.stop = s; v.en = e;
        v.e_state = st; v.e_set = se; v.e_ring = r; v.e_sec = sc;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic m, input logic i, input logic s, input logic t);
        btn_mode = m; btn_inc = i; btn_stop = s; tick_1hz = t;
        cyc();
        btn_mode = 0; btn_inc = 0; btn_stop = 0; tick_1hz = 0;
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) pulse(0, 1, 0, 0);
    endtask

    task automatic retrigger(input string name);
        cur_sec = 6'd1;
        cyc();
        cur_sec = 6'd0;
        cyc();
        check({name, "_state"}, state, 5);
        check({name, "_ring"}, ring, 1);
    endtask

    initial begin
        reset_n = 0; tick_1hz = 0; btn_mode = 0; btn_inc = 0; btn_stop = 0;
        alarm_en = 1; cur_hour = 5'd12; cur_min = 6'd0; cur_sec = 6'd0;
        #1;
        check("rst_state", state, 0);
        check("rst_ring", ring, 0);
        check("rst_setting", setting, 0);
        check("rst_hour", alarm_hour, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1;
        cyc();

        vecs[0]  = mk(1, 0, 0, 1, 3'd1, 1, 0, 6'd0);
        vecs[1]  = mk(1, 0, 0, 1, 3'd2, 1, 0, 6'd0);
        vecs[2]  = mk(1, 0, 0, 1, 3'd3, 1, 0, 6'd0);
        for (int k = 0; k < 7; k++) vecs[3+k] = mk(0, 1, 0, 1, 3'd3, 1, 0, 6'(k + 1));
        vecs[10] = mk(0, 0, 0, 0, 3'd3, 1, 0, 6'd7);

        for (int k = 0; k < 11; k++) begin
            alarm_en = vecs[k].en;
            pulse(vecs[k].mode, vecs[k].inc, vecs[k].stop, 0);
            check($sformatf("vec%0d_state", k), state, vecs[k].e_state);
            check($sformatf("vec%0d_setting", k), setting, vecs[k].e_set);
            check($sformatf("vec%0d_ring", k), ring, vecs[k].e_ring);
            check($sformatf("vec%0d_sec", k), alarm_sec, vecs[k].e_sec);
        end
        alarm_en = 1;

        pulse(1, 0, 0, 0);
        check("arm_state", state, 4);
        pulse(1, 0, 0, 0);
        check("rearm_sethour", state, 1);
        incs(23);
        check("hour_23", alarm_hour, 23);
        incs(1);
        check("hour_wrap", alarm_hour, 0);
        check("hour_wrap_min", alarm_min, 0);
        check("hour_wrap_sec", alarm_sec, 7);
        incs(6);
        pulse(1, 0, 0, 0);
        check("setmin_state", state, 2);
        incs(59);
        check("min_59", alarm_min, 59);
        incs(1);
        check("min_wrap", alarm_min, 0);
        check("min_wrap_hour", alarm_hour, 6);
        incs(30);
        pulse(1, 0, 0, 0);
        incs(53);
        check("sec_wrap", alarm_sec, 0);
        pulse(1, 0, 0, 0);
        check("armed_state", state, 4);
        check("armed_setting", setting, 0);

        cur_hour = 5'd6; cur_min = 6'd29; cur_sec = 6'd59;
        cyc();
        check("premat_state", state, 4);
        cur_min = 6'd30; cur_sec = 6'd0;
        #1;
        check("match_ring_pre", ring, 0);
        cyc();
        check("match_ring", ring, 1);
        check("match_state", state, 5);
        for (int k = 0; k < 3; k++) begin
            pulse(0, 0, 0, 1);
            cyc();
            if (k < 2) check($sformatf("tick%0d_state", k), state, 5);
        end
        check("ring_done_state", state, 4);
        check("ring_done_ring", ring, 0);
        repeat (5) cyc();
        check("no_retrig_state", state, 4);
        check("no_retrig_ring", ring, 0);

        retrigger("rt1");
        pulse(1, 0, 1, 0);
        check("stopwins_state", state, 4);
        check("stopwins_ring", ring, 0);
        check("stopwins_setting", setting, 0);

        retrigger("rt2");
        alarm_en = 0;
        cyc();
        check("en_low_state", state, 0);
        check("en_low_ring", ring, 0);
        alarm_en = 1;

        repeat (4) pulse(1, 0, 0, 0);
        repeat (2) cyc();
        check("rearm_state", state, 4);
        check("rearm_hour", alarm_hour, 6);
        check("rearm_min", alarm_min, 30);

        retrigger("rt3");
        pulse(0, 1, 0, 0);
`ifdef ALARM_SNOOZE_EN
        check("snooze_state", state, 6);
        check("snooze_ring", ring, 0);
        pulse(0, 0, 0, 1);
        cyc();
        check("snooze_t1_state", state, 6);
        pulse(0, 0, 0, 1);
        check("snooze_end_state", state, 5);
        check("snooze_end_ring", ring, 1);
`else
        check("inc_ignored_state", state, 5);
        check("inc_ignored_ring", ring, 1);
`endif
        pulse(0, 0, 1, 0);
        check("stop_state", state, 4);

        retrigger("rt4");
        #2 reset_n = 0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_ring", ring, 0);
        check("async_rst_setting", setting, 0);
        check("async_rst_hour", alarm_hour, 0);
        check("async_rst_min", alarm_min, 0);
        check("async_rst_sec", alarm_sec, 0);
        @(negedge clock) reset_n = 1;
        repeat (2) cyc();
        check("post_rst_state", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SECS, default 60, meaning ring duration in tick_1hz periods (1..255).
REQ-002 SHALL have parameter SNOOZE_SECS, default 300, meaning snooze pause in tick_1hz periods (1..1023).
REQ-003 SHALL have port clock  in  1  system clock.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tick_1hz  in  1  one-cycle strobe per second.
REQ-006 SHALL have ports btn_mode, btn_inc, btn_stop  in  1 each  debounced single-cycle button pulses.
REQ-007 SHALL have port alarm_en  in  1  level switch arming the alarm.
REQ-008 SHALL have ports cur_hour  in  5, cur_min  in  6, cur_sec  in  6  running clock time.
REQ-009 SHALL have ports alarm_hour  out  5, alarm_min  out  6, alarm_sec  out  6  stored alarm time.
REQ-010 SHALL have port state  out  3  current FSM state code.
REQ-011 SHALL have ports setting  out  1 (high in any SET_* state) and ring  out  1 (buzzer drive).

Function
REQ-012 SHALL implement states IDLE=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, ARMED=4, RINGING=5, SNOOZE=6; code 7 SHALL recover to IDLE next cycle.
REQ-013 SHALL apply per-cycle input priority: alarm_en low > btn_stop > btn_mode > btn_inc.
REQ-014 SHALL advance IDLE->SET_HOUR->SET_MIN->SET_SEC on btn_mode; btn_mode in SET_SEC SHALL go to ARMED if alarm_en else IDLE.
REQ-015 SHALL, on btn_inc in SET_HOUR/SET_MIN/SET_SEC, increment the selected field by 1 next cycle, wrapping 23->0 (hour) and 59->0 (min, sec); other fields unchanged.
REQ-016 SHALL go ARMED->SET_HOUR on btn_mode; alarm_en low in ARMED, RINGING or SNOOZE SHALL go to IDLE next cycle with ring=0; alarm_en SHALL NOT affect IDLE or SET_* states.
REQ-017 SHALL trigger when cur_*==alarm_* and previous-cycle compare was false (rising edge only); in ARMED this SHALL enter RINGING next edge and load ring counter with RING_SECS.
REQ-018 SHALL drive ring registered, high exactly while state==RINGING (first high cycle = cycle after trigger).
REQ-019 SHALL decrement ring counter on tick_1hz in RINGING; reaching 0 SHALL return to ARMED.
REQ-020 SHALL return RINGING->ARMED on btn_stop; a held match SHALL NOT re-trigger (edge rule, REQ-017).
REQ-021 SHALL ignore btn_inc outside SET_* states unless ALARM_SNOOZE_EN applies.
REQ-022 SHALL size counters via $clog2 of parameter+1; no counter SHALL wrap below 0.

Reset
REQ-023 SHALL, on reset_n low, immediately force state=IDLE, alarm_hour/min/sec=0, ring=0, setting=0, counters=0, compare history=1 (no trigger on first post-reset cycle).
REQ-024 SHALL treat reset mid-RINGING or mid-SET identically (all values lost).

Configuration
REQ-025 SHALL, with ALARM_SNOOZE_EN defined, go RINGING->SNOOZE on btn_inc, load snooze counter SNOOZE_SECS, decrement on tick_1hz, and at 0 re-enter RINGING with counter reloaded RING_SECS; btn_stop in SNOOZE SHALL go to ARMED.
REQ-026 SHALL, without ALARM_SNOOZE_EN, omit snooze counter and SNOOZE state; btn_inc in RINGING ignored; code 6 treated as illegal (REQ-012).

Structure
REQ-027 SHALL place state enumeration codes and field limits (HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59) in shared package clock_pkg.
REQ-028 SHALL instantiate three copies of sub-module alarm_field_cnt (modulo-N load-free increment counter, MAX parameter, async active-low reset).

Verification
REQ-029 SHALL cover: reset, 3x btn_mode, 7x btn_inc in SET_SEC -> alarm_sec=7, state=SET_SEC.
REQ-030 SHALL cover: hour 23 + btn_inc -> hour 0; min 59 + btn_inc -> min 0.
REQ-031 SHALL cover: alarm 06:30:00 armed, cur_* steps to 06:30:00 -> ring=1 one cycle later; RING_SECS=3, 3 ticks -> ARMED, ring=0, no retrigger while match holds.
REQ-032 SHALL cover: ringing + btn_stop and btn_mode same cycle -> ARMED (stop wins); ringing + alarm_en low -> IDLE.
REQ-033 SHALL cover (ALARM_SNOOZE_EN, SNOOZE_SECS=2): btn_inc while ringing -> SNOOZE, ring=0; 2 ticks -> RINGING, ring=1.
REQ-034 SHALL cover: reset_n low mid-RINGING -> ring=0, state=0, alarm fields 0 without clock edge.
